// File: rtl/rv64_pkg.sv
// RV64I shared definitions: widths, base opcodes and the ID/EX bundle.
// Imported by the decode/issue stage and the immediate generator.
package rv64_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int RIDX = $clog2(NREG);

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            reg_write;
    } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV64I immediate generator, sign-extended from instr[31].
// Shared by the decode stage and its EX/MEM neighbours.
module imm_gen
    import rv64_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic sgn;

    assign sgn = instr[31];

    always_comb begin
        imm = '0;
        unique case (instr[6:0])
            LOAD, OP_IMM, OP_IMM_32, JALR:
                imm = {{(XLEN-12){sgn}}, instr[31:20]};
            STORE:
                imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
            BRANCH:
                imm = {{(XLEN-13){sgn}}, sgn, instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:
                imm = {{(XLEN-32){sgn}}, instr[31:12], 12'h000};
            JAL:
                imm = {{(XLEN-21){sgn}}, sgn, instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV64I decode/issue: field split, busy scoreboard for RAW/WAW,
// and a single ID/EX register with a valid/ready handshake.
module decode_issue_stage
    import rv64_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic [RIDX-1:0] rs1,
    output logic [RIDX-1:0] rs2,
    input  logic [XLEN-1:0] read1,
    input  logic [XLEN-1:0] read2,
    input  logic            wb_en,
    input  logic [RIDX-1:0] wb_rd,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [RIDX-1:0] ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_reg_write
);

    logic [6:0]      opcode;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            use1;
    logic            use2;
    logic            hazard;
    logic            issue;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    id_ex_t          ex_q;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    always_comb begin
        reg_write = 1'b0;
        use1      = 1'b0;
        use2      = 1'b0;
        unique case (opcode)
            LUI, AUIPC, JAL: begin
                reg_write = 1'b1;
            end
            JALR, LOAD, OP_IMM, OP_IMM_32: begin
                reg_write = 1'b1;
                use1      = 1'b1;
            end
            OP, OP_32: begin
                reg_write = 1'b1;
                use1      = 1'b1;
                use2      = 1'b1;
            end
            BRANCH, STORE: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: begin
                reg_write = 1'b0;
            end
        endcase
        if (rd == '0)
            reg_write = 1'b0;
    end

    assign hazard = (use1 & busy[rs1])
                  | (use2 & busy[rs2])
                  | (reg_write & busy[rd]);

    assign in_ready = !hazard && (!ex_valid || ex_ready) && !flush;
    assign issue    = in_valid && in_ready;

    // Set is applied last so a new writer beats a retiring older one.
    always_comb begin
        busy_next = busy;
        if (wb_en)
            busy_next[wb_rd] = 1'b0;
        if (flush && ex_valid && ex_q.reg_write)
            busy_next[ex_q.rd] = 1'b0;
        if (issue && reg_write)
            busy_next[rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid         <= 1'b1;
            ex_q.rs1_val     <= read1;
            ex_q.rs2_val     <= read2;
            ex_q.imm         <= imm;
            ex_q.rd          <= rd;
            ex_q.opcode      <= opcode;
            ex_q.funct3      <= in_instr[14:12];
            ex_q.funct7b5    <= in_instr[30];
            ex_q.reg_write   <= reg_write;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_rs1_val   = ex_q.rs1_val;
    assign ex_rs2_val   = ex_q.rs2_val;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct3    = ex_q.funct3;
    assign ex_funct7b5  = ex_q.funct7b5;
    assign ex_reg_write = ex_q.reg_write;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed plan then random traffic
// against a set-based reference model of decode, hazards and the handshake.
module tb_decode_issue_stage;
    import rv64_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [4:0]  rs1, rs2;
    logic [63:0] read1, read2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_reg_write;

    decode_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .read1        (read1),
        .read2        (read2),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rs1_val   (ex_rs1_val),
        .ex_rs2_val   (ex_rs2_val),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_opcode    (ex_opcode),
        .ex_funct3    (ex_funct3),
        .ex_funct7b5  (ex_funct7b5),
        .ex_reg_write (ex_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        rw;
    } exp_t;

    exp_t        q[$];
    bit          occ;
    logic [31:0] busy_m;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit writes(logic [31:0] i);
        if (i[11:7] == 5'd0)
            return 1'b0;
        return i[6:0] inside {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM,
                              OP, OP_IMM_32, OP_32};
    endfunction

    function automatic bit reads1(logic [31:0] i);
        return i[6:0] inside {JALR, LOAD, OP_IMM, OP, OP_IMM_32,
                              OP_32, BRANCH, STORE};
    endfunction

    function automatic bit reads2(logic [31:0] i);
        return i[6:0] inside {OP, OP_32, BRANCH, STORE};
    endfunction

    function automatic logic [63:0] imm_of(logic [31:0] i);
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] u32;
        case (i[6:0])
            LOAD, OP_IMM, OP_IMM_32, JALR: begin
                s12 = i[31:20];
                return longint'(s12);
            end
            STORE: begin
                s12 = {i[31:25], i[11:7]};
                return longint'(s12);
            end
            BRANCH: begin
                b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
                return longint'(b13);
            end
            LUI, AUIPC: begin
                u32 = {i[31:12], 12'h000};
                return longint'(u32);
            end
            JAL: begin
                j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
                return longint'(j21);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[13];
        logic [31:0] i;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM,
                OP, OP_IMM_32, OP_32, 7'h0F, 7'h73};
        i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 12)];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(bit v, logic [31:0] ins, bit er, bit we,
                        logic [4:0] wr, bit fl, bit rs);
        bit          hz, rdy, iss;
        logic [31:0] nb;
        exp_t        e;
        chk("ex_valid", 64'(ex_valid), 64'(occ));
        chk("busy", 64'(dut.busy), 64'(busy_m));
        rst      = rs;
        in_valid = v;
        in_instr = ins;
        ex_ready = er;
        wb_en    = we;
        wb_rd    = wr;
        flush    = fl;
        read1    = {$urandom, $urandom};
        read2    = {$urandom, $urandom};
        #1;
        hz = (reads1(ins) && busy_m[ins[19:15]])
          || (reads2(ins) && busy_m[ins[24:20]])
          || (writes(ins) && busy_m[ins[11:7]]);
        rdy = !hz && (!occ || er) && !fl;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("rs1", 64'(rs1), 64'(ins[19:15]));
        chk("rs2", 64'(rs2), 64'(ins[24:20]));
        iss = v && rdy && !rs;
        if (rs) begin
            q.delete();
            occ    = 1'b0;
            busy_m = '0;
        end else begin
            nb = busy_m;
            if (we)
                nb[wr] = 1'b0;
            if (fl && occ && q.size() > 0) begin
                if (q[0].rw)
                    nb[q[0].rd] = 1'b0;
                void'(q.pop_front());
            end
            if (iss) begin
                e.r1  = read1;
                e.r2  = read2;
                e.imm = imm_of(ins);
                e.rd  = ins[11:7];
                e.op  = ins[6:0];
                e.f3  = ins[14:12];
                e.f7  = ins[30];
                e.rw  = writes(ins);
                q.push_back(e);
                if (e.rw)
                    nb[ins[11:7]] = 1'b1;
            end
            nb[0]  = 1'b0;
            busy_m = nb;
            if (fl)
                occ = 1'b0;
            else if (iss)
                occ = 1'b1;
            else if (er)
                occ = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid && !flush) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ex_spurious: got ex_valid=1 expected 0");
            end else begin
                chk("ex_rs1_val", ex_rs1_val, q[0].r1);
                chk("ex_rs2_val", ex_rs2_val, q[0].r2);
                chk("ex_imm", ex_imm, q[0].imm);
                chk("ex_rd", 64'(ex_rd), 64'(q[0].rd));
                chk("ex_opcode", 64'(ex_opcode), 64'(q[0].op));
                chk("ex_funct3", 64'(ex_funct3), 64'(q[0].f3));
                chk("ex_funct7b5", 64'(ex_funct7b5), 64'(q[0].f7));
                chk("ex_reg_write", 64'(ex_reg_write), 64'(q[0].rw));
                if (ex_ready)
                    void'(q.pop_front());
            end
        end
    end

    localparam logic [31:0] ADDI_X2 = 32'h00500113;
    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] SW_X2   = 32'hFE20AE23;
    localparam logic [31:0] LUI_X5  = 32'h800002B7;
    localparam logic [31:0] ADDI_X0 = 32'h00100013;
    localparam logic [31:0] ADDI_X6 = 32'h00200313;
    localparam logic [31:0] ADDI_X9 = 32'h00300493;
    localparam logic [31:0] ADDI_X4 = 32'h00100213;
    localparam logic [31:0] ADDI_X7 = 32'h00100393;

    initial begin
        bit          v, er, we, fl, rs;
        logic [4:0]  wr;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        ex_ready = 1'b0;
        wb_en    = 1'b0;
        wb_rd    = '0;
        flush    = 1'b0;
        read1    = '0;
        read2    = '0;
        occ      = 1'b0;
        busy_m   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_imm", ex_imm, 64'd0);
        chk("rst_ex_rs1_val", ex_rs1_val, 64'd0);
        chk("rst_ex_rd", 64'(ex_rd), 64'd0);
        chk("rst_ex_reg_write", 64'(ex_reg_write), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        step(1, ADDI_X2, 1, 0, 0, 0, 0);
        chk("addi_imm", ex_imm, 64'd5);
        chk("addi_rd", 64'(ex_rd), 64'd2);
        chk("addi_rw", 64'(ex_reg_write), 64'd1);
        chk("addi_busy2", 64'(dut.busy[2]), 64'd1);

        step(1, ADD_X3, 1, 0, 0, 0, 0);
        step(1, ADD_X3, 1, 1, 5'd2, 0, 0);
        step(1, ADD_X3, 1, 0, 0, 0, 0);
        chk("add_rd", 64'(ex_rd), 64'd3);
        chk("add_valid", 64'(ex_valid), 64'd1);

        step(1, SW_X2, 1, 0, 0, 0, 0);
        chk("sw_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sw_rw", 64'(ex_reg_write), 64'd0);

        step(1, LUI_X5, 1, 0, 0, 0, 0);
        chk("lui_imm", ex_imm, 64'hFFFF_FFFF_8000_0000);

        step(1, ADDI_X0, 1, 0, 0, 0, 0);
        chk("x0_rw", 64'(ex_reg_write), 64'd0);
        step(1, ADDI_X6, 1, 0, 0, 0, 0);
        chk("x0_read_rd", 64'(ex_rd), 64'd6);

        repeat (3) step(1, ADDI_X9, 0, 0, 0, 0, 0);
        chk("bp_hold_rd", 64'(ex_rd), 64'd6);
        step(1, ADDI_X9, 1, 0, 0, 0, 0);
        chk("bp_resume_rd", 64'(ex_rd), 64'd9);

        step(1, ADDI_X4, 1, 0, 0, 0, 0);
        step(1, ADDI_X7, 1, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 5'd4, 1, 0);
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_busy7", 64'(dut.busy[7]), 64'd0);
        chk("flush_busy4", 64'(dut.busy[4]), 64'd0);

        step(1, ADDI_X7, 1, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 1, 1);
        chk("rstfl_valid", 64'(ex_valid), 64'd0);
        chk("rstfl_busy", 64'(dut.busy), 64'd0);
        chk("rstfl_imm", ex_imm, 64'd0);

        for (int n = 0; n < 2000; n++) begin
            v  = $urandom_range(0, 3) != 0;
            er = $urandom_range(0, 3) != 0;
            we = $urandom_range(0, 2) == 0;
            wr = 5'($urandom_range(0, 7));
            fl = $urandom_range(0, 19) == 0;
            rs = $urandom_range(0, 199) == 0;
            if (fl)
                er = 1'b0;
            step(v, rand_instr(), er, we, wr, fl, rs);
        end

        repeat (3) step(0, 32'h0, 1, 0, 0, 0, 0);
        chk("drain", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
